// File: rtl/qdec_pkg.sv
// Shared quadrature phase encodings, pipeline constants and step classification.
// Pure definitions; no latency and no flow control.
package qdec_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    localparam int SYNC_DEPTH   = 2;
    localparam int FILT_LEN_DEF = 3;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ILL
    } step_t;

    // Phases are {A,B}; a double-bit change cannot be ordered, so it is illegal.
    function automatic step_t classify(input logic [1:0] prev, input logic [1:0] cur);
        step_t s;
        if (prev == cur)
            s = STEP_NONE;
        else if ((prev ^ cur) == 2'b11)
            s = STEP_ILL;
        else if ((prev == PH_00 && cur == PH_01) ||
                 (prev == PH_01 && cur == PH_11) ||
                 (prev == PH_11 && cur == PH_10) ||
                 (prev == PH_10 && cur == PH_00))
            s = STEP_FWD;
        else
            s = STEP_REV;
        return s;
    endfunction

endpackage

// File: rtl/qdec_glitch_filter.sv
// Accepts a synchronized level only after FILT_LEN consecutive equal samples.
// Adds FILT_LEN cycles of latency; always ready, shorter pulses are dropped.
module qdec_glitch_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic d_vld,
    output logic q,
    output logic q_vld
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic          cand;
    logic [CW-1:0] run;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cand  <= 1'b0;
            run   <= '0;
            q     <= 1'b0;
            q_vld <= 1'b0;
        end else if (d_vld) begin
            // run counts samples equal to cand; zero means no candidate yet
            if (run == '0 || d != cand) begin
                cand <= d;
                run  <= CW'(1);
            end else begin
                if (run < CW'(FILT_LEN))
                    run <= run + 1'b1;
                if (run >= CW'(FILT_LEN - 1)) begin
                    q     <= d;
                    q_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/quad_dir_decoder.sv
// Quadrature direction decoder: count strobe + direction, illegal-jump flag; optional QDEC_FILTER_EN glitch filter.
// Latency 3 cycles input->cnt_en (+FILT_LEN with filter); no backpressure, one strobe per accepted phase change.
module quad_dir_decoder
    import qdec_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic qa,
    input  logic qb,
    input  logic err_clr,
    output logic ud,
    output logic cnt_en,
    output logic err,
    output logic err_sticky
);

    logic [SYNC_DEPTH-1:0] sync_a;
    logic [SYNC_DEPTH-1:0] sync_b;
    logic [SYNC_DEPTH-1:0] sync_vld;
    logic [1:0]            cur;
    logic                  cur_vld;
    logic [1:0]            prev;
    logic                  primed;
    step_t                 step;

    // sync_vld marks stages that hold a real post-reset sample, not the reset value
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_a   <= '0;
            sync_b   <= '0;
            sync_vld <= '0;
        end else begin
            sync_a   <= {sync_a[SYNC_DEPTH-2:0], qa};
            sync_b   <= {sync_b[SYNC_DEPTH-2:0], qb};
            sync_vld <= {sync_vld[SYNC_DEPTH-2:0], 1'b1};
        end
    end

`ifdef QDEC_FILTER_EN
    logic vld_a;
    logic vld_b;

    qdec_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk   (clk),
        .rst   (rst),
        .d     (sync_a[SYNC_DEPTH-1]),
        .d_vld (sync_vld[SYNC_DEPTH-1]),
        .q     (cur[1]),
        .q_vld (vld_a)
    );

    qdec_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk   (clk),
        .rst   (rst),
        .d     (sync_b[SYNC_DEPTH-1]),
        .d_vld (sync_vld[SYNC_DEPTH-1]),
        .q     (cur[0]),
        .q_vld (vld_b)
    );

    assign cur_vld = vld_a & vld_b;
`else
    logic unused_filt_len;

    assign unused_filt_len = (FILT_LEN > 8);
    assign cur             = {sync_a[SYNC_DEPTH-1], sync_b[SYNC_DEPTH-1]};
    assign cur_vld         = sync_vld[SYNC_DEPTH-1];
`endif

    assign step = classify(prev, cur);

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev       <= PH_00;
            primed     <= 1'b0;
            ud         <= 1'b0;
            cnt_en     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            cnt_en <= 1'b0;
            err    <= 1'b0;
            if (err_clr)
                err_sticky <= 1'b0;
            if (cur_vld) begin
                prev   <= cur;
                primed <= 1'b1;
                // first accepted phase only seeds prev
                if (primed && en) begin
                    case (step)
                        STEP_FWD: begin
                            cnt_en <= 1'b1;
                            ud     <= 1'b1;
                        end
                        STEP_REV: begin
                            cnt_en <= 1'b1;
                            ud     <= 1'b0;
                        end
                        STEP_ILL: begin
                            err        <= 1'b1;
                            err_sticky <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
